// File: rtl/knips_pkg.sv
// Shared KNIPS opcode map: mnemonics, decoded control flags and legality check.
package knips_pkg;

  localparam int OP_BITS = 5;

  typedef enum logic [OP_BITS-1:0] {
    sfrr   = 5'b00000,
    lbr    = 5'b00001,
    sbr    = 5'b00010,
    mov    = 5'b00011,
    movr   = 5'b00100,
    xorr   = 5'b00101,
    orr    = 5'b00110,
    andi   = 5'b10111,
    branch = 5'b11000,
    jump   = 5'b11001,
    xori   = 5'b11010,
    addi   = 5'b11011,
    sfri   = 5'b11100,
    sfli   = 5'b11101,
    set    = 5'b11110
  } op_mne;

  typedef struct packed {
    logic is_imm;
    logic reg_we;
    logic mem_rd;
    logic mem_wr;
    logic is_ctrl;
    logic illegal;
  } ctrl_bundle_t;

  function automatic logic is_legal(input logic [OP_BITS-1:0] op);
    case (op)
      sfrr, lbr, sbr, mov, movr, xorr, orr,
      andi, branch, jump, xori, addi, sfri, sfli, set: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/knips_op_decode.sv
// Combinational opcode classifier: control flags plus immediate sign-extension select.
module knips_op_decode
  import knips_pkg::*;
(
  input  logic [OP_BITS-1:0] op,
  output ctrl_bundle_t       ctrl,
  output logic               sext
);

  // Illegal opcodes keep their format bit but get no enables.
  always_comb begin
    ctrl        = '0;
    sext        = 1'b0;
    ctrl.is_imm = op[OP_BITS-1];
    if (!is_legal(op)) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (op)
        lbr: begin
          ctrl.mem_rd = 1'b1;
          ctrl.reg_we = 1'b1;
        end
        sbr: ctrl.mem_wr = 1'b1;
        branch, jump: begin
          ctrl.is_ctrl = 1'b1;
          sext         = 1'b1;
        end
        addi: begin
          ctrl.reg_we = 1'b1;
          sext        = 1'b1;
        end
        default: ctrl.reg_we = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/knips_decode_stage.sv
// Registered decode stage: handshake holding register, control-hazard FSM, illegal counter.
module knips_decode_stage
  import knips_pkg::*;
#(
  parameter int INSTR_W = 9,
  parameter int OP_W    = 5,
  parameter int REG_W   = 2,
  parameter int DW      = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_op,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs,
  output logic [DW-1:0]      out_imm,
  output logic               out_is_imm,
  output logic               out_reg_we,
  output logic               out_mem_rd,
  output logic               out_mem_wr,
  output logic               out_is_ctrl,
  output logic               out_illegal,
  input  logic               ctrl_done,
  input  logic               flush,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int IMM_W = INSTR_W - OP_W;

  typedef enum logic {RUN, WAIT_CTRL} state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    op;
  logic [IMM_W-1:0]   imm_field;
  ctrl_bundle_t       dec, ctrl_q;
  logic               dec_sext;
  logic [REG_W-1:0]   dec_rd, dec_rs;
  logic [DW-1:0]      dec_imm;
  logic               accept;

  assign op        = in_instr[INSTR_W-1 -: OP_W];
  assign imm_field = in_instr[IMM_W-1:0];

  knips_op_decode u_op_decode (
    .op   (op),
    .ctrl (dec),
    .sext (dec_sext)
  );

  // I-type instructions address the accumulator, so both register fields read as zero.
  always_comb begin
    dec_rd  = '0;
    dec_rs  = '0;
    dec_imm = '0;
    if (!op[OP_W-1]) begin
      dec_rd = in_instr[2*REG_W-1:REG_W];
      dec_rs = in_instr[REG_W-1:0];
    end else if (dec_sext) begin
      dec_imm = DW'($signed(imm_field));
    end else begin
      dec_imm = DW'(imm_field);
    end
  end

  assign in_ready = (state_q == RUN) && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Issue stays blocked behind a branch/jump until execute resolves it or the pipe is flushed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (accept && dec.is_ctrl) state_d = WAIT_CTRL;
      WAIT_CTRL: if (ctrl_done || flush)    state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_rd    <= '0;
      out_rs    <= '0;
      out_imm   <= '0;
      ctrl_q    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op    <= op;
      out_rd    <= dec_rd;
      out_rs    <= dec_rs;
      out_imm   <= dec_imm;
      ctrl_q    <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      illegal_cnt <= '0;
    else if (accept && dec.illegal && (illegal_cnt != {CNT_W{1'b1}}))
      illegal_cnt <= illegal_cnt + 1'b1;
  end

  assign out_is_imm  = ctrl_q.is_imm;
  assign out_reg_we  = ctrl_q.reg_we;
  assign out_mem_rd  = ctrl_q.mem_rd;
  assign out_mem_wr  = ctrl_q.mem_wr;
  assign out_is_ctrl = ctrl_q.is_ctrl;
  assign out_illegal = ctrl_q.illegal;

endmodule
